// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } sar_state_t;

   // Comparator flags are trustworthy only when exactly one of them is asserted.
   function automatic logic flags_legal(input logic g, input logic s, input logic e);
      return (g & ~s & ~e) | (~g & s & ~e) | (~g & ~s & e);
   endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable down-counter with a zero flag; paces each trial's settle window.
module sar_settle_timer #(
   parameter int unsigned CW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt_r;

   // Counter register: load wins, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/sar_search.sv
// SAR search controller driving a magnitude comparator's B operand.
// Optional build macro SAR_EARLY_EXIT_EN: finish as soon as Equal is sampled.
module sar_search
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             Greater,
   input  logic             Smaller,
   input  logic             Equal,
   output logic [WIDTH-1:0] Trial,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Found,
   output logic             Error
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   sar_state_t       state_r, state_nx_s;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] p_r, trial_r, result_r;
   logic             busy_r, done_r, found_r, error_r;

   logic             accept_s, sample_s, legal_s, early_s, last_s, load_s, cnt_zero_s;
   logic [WIDTH-1:0] bit_s, p_upd_s;

   assign accept_s = (state_r == IDLE) && Start;
   assign sample_s = (state_r == RUN) && cnt_zero_s;
   assign legal_s  = flags_legal(Greater, Smaller, Equal);
   assign last_s   = (idx_r == {IW{1'b0}});
   assign bit_s    = {{(WIDTH-1){1'b0}}, 1'b1} << idx_r;
   // Equal keeps the bit just like Greater.
   assign p_upd_s  = (Greater | Equal) ? (p_r | bit_s) : (p_r & ~bit_s);
`ifdef SAR_EARLY_EXIT_EN
   assign early_s  = legal_s & Equal;
`else
   assign early_s  = 1'b0;
`endif
   assign load_s   = accept_s | (sample_s & legal_s & ~last_s & ~early_s);

   sar_settle_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .load_val (CW'(SETTLE - 1)),
      .zero     (cnt_zero_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (Start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         RUN: begin
            if (sample_s && (!legal_s || last_s || early_s)) state_nx_s = FIN;
            else                                              state_nx_s = RUN;
         end
         FIN:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r    <= {IW{1'b0}};
         p_r      <= {WIDTH{1'b0}};
         trial_r  <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         found_r  <= 1'b0;
         error_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == FIN);
         case (state_r)
            IDLE: begin
               if (Start) begin
                  p_r      <= {WIDTH{1'b0}};
                  idx_r    <= IW'(WIDTH - 1);
                  trial_r  <= {1'b1, {(WIDTH-1){1'b0}}};
                  result_r <= {WIDTH{1'b0}};
                  found_r  <= 1'b0;
                  error_r  <= 1'b0;
               end else begin
                  trial_r  <= {WIDTH{1'b0}};
               end
            end
            RUN: begin
               if (sample_s && !legal_s) begin
                  error_r  <= 1'b1;
                  result_r <= {WIDTH{1'b0}};
                  found_r  <= 1'b0;
               end else if (sample_s) begin
                  p_r <= p_upd_s;
                  if (Equal) found_r <= 1'b1;
                  if (early_s) begin
                     result_r <= trial_r;
                  end else if (last_s) begin
                     result_r <= p_upd_s;
                  end else begin
                     idx_r   <= idx_r - {{(IW-1){1'b0}}, 1'b1};
                     trial_r <= p_upd_s | (bit_s >> 1);
                  end
               end else begin
                  trial_r <= trial_r;
               end
            end
            FIN:     trial_r <= {WIDTH{1'b0}};
            default: trial_r <= {WIDTH{1'b0}};
         endcase
      end
   end

   assign Trial  = trial_r;
   assign Busy   = busy_r;
   assign Done   = done_r;
   assign Result = result_r;
   assign Found  = found_r;
   assign Error  = error_r;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=4, SETTLE=2) with a behavioural comparator.
module tb_sar_search;

   logic       clk = 1'b0;
   logic       rst, Start;
   logic       Greater, Smaller, Equal;
   logic [3:0] Trial, Result;
   logic       Busy, Done, Found, Error;

   logic [3:0] a_val;
   logic       force_gs;
   int         checks = 0;
   int         errors = 0;

   int          dcyc;
   logic [15:0] trs;
   logic        done_after;

   always #5 clk = ~clk;

   // Comparator with the unknown on A and Trial on B; force_gs injects an illegal flag set.
   assign Greater = force_gs | (a_val > Trial);
   assign Smaller = force_gs | (a_val < Trial);
   assign Equal   = ~force_gs & (a_val == Trial);

   sar_search #(.WIDTH(4), .SETTLE(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .Start  (Start),
      .Greater(Greater),
      .Smaller(Smaller),
      .Equal  (Equal),
      .Trial  (Trial),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result),
      .Found  (Found),
      .Error  (Error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept a search, log distinct trials while Busy, and return the Done cycle (0 = none).
   task automatic run(input logic [3:0] a, input int pulse_cyc,
                      output int done_cyc, output logic [15:0] tr, output logic d_after);
      logic [3:0] last;
      a_val = a;
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      done_cyc = 0;
      tr = 16'h0000;
      last = 4'h0;
      for (int k = 1; k <= 20; k++) begin
         if (Busy && Trial !== last) begin
            tr = {tr[11:0], Trial};
            last = Trial;
         end
         if (Done) begin
            done_cyc = k;
            break;
         end
         Start = (k == pulse_cyc) || (k == pulse_cyc + 1);
         @(posedge clk);
         #1;
      end
      Start = 1'b0;
      @(posedge clk);
      #1 d_after = Done;
   endtask

   initial begin
      rst = 1'b1; Start = 1'b0; a_val = 4'h0; force_gs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_trial", Trial, 4'h0);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_result", Result, 4'h0);
      check("rst_found", Found, 1'b0);
      check("rst_error", Error, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // A=12: Equal at the second trial.
      run(4'd12, 0, dcyc, trs, done_after);
`ifdef SAR_EARLY_EXIT_EN
      check("a12_trials", trs, 16'h008C);
      check("a12_done", dcyc, 5);
`else
      check("a12_trials", trs, 16'h8CED);
      check("a12_done", dcyc, 9);
`endif
      check("a12_result", Result, 4'd12);
      check("a12_found", Found, 1'b1);
      check("a12_pulse", done_after, 1'b0);

      // A=0: all Smaller.
      run(4'd0, 0, dcyc, trs, done_after);
      check("a0_trials", trs, 16'h8421);
      check("a0_done", dcyc, 9);
      check("a0_result", Result, 4'd0);
      check("a0_found", Found, 1'b0);
      check("a0_error", Error, 1'b0);

      // A=15: Greater until the final Equal.
      run(4'd15, 0, dcyc, trs, done_after);
      check("a15_trials", trs, 16'h8CEF);
      check("a15_done", dcyc, 9);
      check("a15_result", Result, 4'd15);
      check("a15_found", Found, 1'b1);

      // Illegal flags at the first sample.
      force_gs = 1'b1;
      run(4'd6, 0, dcyc, trs, done_after);
      force_gs = 1'b0;
      check("err_done", dcyc, 3);
      check("err_error", Error, 1'b1);
      check("err_result", Result, 4'd0);
      check("err_found", Found, 1'b0);
      check("err_sticky", Error, 1'b1);

      // Next Start clears Error.
      run(4'd3, 0, dcyc, trs, done_after);
      check("clr_error", Error, 1'b0);
      check("a3_result", Result, 4'd3);
      check("a3_trials", trs, 16'h8423);

      // Start pulsed mid-search is ignored.
      run(4'd9, 3, dcyc, trs, done_after);
      check("mid_trials", trs, 16'h8CA9);
      check("mid_done", dcyc, 9);
      check("mid_result", Result, 4'd9);
      check("mid_idle", Busy, 1'b0);

      // Reset at cycle 3 of a search.
      a_val = 4'd10;
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_trial", Trial, 4'h0);
      check("mrst_busy", Busy, 1'b0);
      check("mrst_done", Done, 1'b0);
      check("mrst_result", Result, 4'h0);
      check("mrst_found", Found, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_nodone", Done, 1'b0);

      // Restart after reset.
      run(4'd5, 0, dcyc, trs, done_after);
      check("a5_trials", trs, 16'h8465);
      check("a5_done", dcyc, 9);
      check("a5_result", Result, 4'd5);
      check("a5_found", Found, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
